// File: rtl/ysyx_25040111_axi_mem_slave.sv
// Single-port AXI-style word memory slave with independent read and write FSMs.
// Read bursts (FIXED/INCR) and single-beat writes, each with a fixed LAT-cycle access delay.
module ysyx_25040111_axi_mem_slave #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [7:0]  awlen,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  // Unsigned wrap makes addresses below BASE fail the range test too.
  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  rstate_t     r_state;
  logic [31:0] r_addr, r_step, r_nxt, r_word;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_cnt;
  logic        r_bad, r_ok;

  // Address of the beat about to be presented: the latched one on the first beat,
  // the advanced one on every later beat.
  always_comb begin
    r_step = (r_burst == 2'b01) ? (32'd1 << r_size) : 32'd0;
    r_nxt  = (r_state == R_DATA) ? r_addr + r_step : r_addr;
    r_ok   = !r_bad && in_range(r_nxt);
    r_word = mem[widx(r_nxt)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_bad   <= arburst[1] || (arsize > 3'd2);
            r_cnt   <= 4'(LAT - 1);
            arready <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rdata   <= r_ok ? r_word : 32'd0;
            rresp   <= r_ok ? 2'b00 : 2'b10;
            rlast   <= (r_len == 8'd0);
            r_beat  <= 8'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              rresp   <= '0;
              arready <= 1'b1;
            end else begin
              r_addr <= r_nxt;
              r_beat <= r_beat + 8'd1;
              rdata  <= r_ok ? r_word : 32'd0;
              rresp  <= r_ok ? 2'b00 : 2'b10;
              rlast  <= (r_beat + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_WAIT, W_RESP} wstate_t;
  wstate_t     w_state;
  logic [31:0] w_addr, w_data;
  logic [7:0]  w_len;
  logic [3:0]  w_strb, w_cnt;
  logic        w_last, w_ok, w_commit, aw_hs, w_hs;

  always_comb begin
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    w_ok     = in_range(w_addr) && (w_len == 8'd0) && w_last;
    w_commit = (w_state == W_WAIT) && (w_cnt == 4'd0) && w_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_last  <= 1'b0;
      w_cnt   <= '0;
    end else begin
      if (aw_hs) begin
        w_addr <= awaddr;
        w_len  <= awlen;
      end
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
        w_last <= wlast;
      end
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          wready  <= 1'b1;
          if (aw_hs && w_hs) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            w_cnt   <= 4'(LAT - 1);
            w_state <= W_WAIT;
          end else if (aw_hs) begin
            awready <= 1'b0;
            w_state <= W_ADDR;
          end else if (w_hs) begin
            wready  <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_ADDR: if (w_hs) begin
          wready  <= 1'b0;
          w_cnt   <= 4'(LAT - 1);
          w_state <= W_WAIT;
        end
        W_DATA: if (aw_hs) begin
          awready <= 1'b0;
          w_cnt   <= 4'(LAT - 1);
          w_state <= W_WAIT;
        end
        W_WAIT: begin
          if (w_cnt == 4'd0) begin
            bvalid  <= 1'b1;
            bresp   <= w_ok ? 2'b00 : 2'b10;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 4'd1;
          end
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          bresp   <= '0;
          awready <= 1'b1;
          wready  <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Contents survive reset; a read racing this commit sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_commit)
      for (int b = 0; b < 4; b++)
        if (w_strb[b]) mem[widx(w_addr)][8*b +: 8] <= w_data[8*b +: 8];
  end
endmodule

// File: tb/tb_ysyx_25040111_axi_mem_slave.sv
// Bench for the AXI memory slave: directed corner cases plus random traffic
// checked against an array model of memory and the burst/response rules.
module tb_ysyx_25040111_axi_mem_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;

  logic        clk, rst_n;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp, bresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  ysyx_25040111_axi_mem_slave #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] mm [DEPTH];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a - BASE) < 32'(4 * DEPTH);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [7:0] len, input logic last, input int gap);
    int  aw_at, w_at, cyc, n, hold;
    bit  aw_done, w_done, aw_h, w_h, ok;
    aw_at = (gap < 0) ? -gap : 0;
    w_at  = (gap > 0) ? gap : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      if (!aw_done && cyc >= aw_at) begin awvalid = 1'b1; awaddr = a; awlen = len; end
      if (!w_done && cyc >= w_at) begin wvalid = 1'b1; wdata = d; wstrb = s; wlast = last; end
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      @(posedge clk);
      if (aw_h) aw_done = 1;
      if (w_h)  w_done  = 1;
      cyc++;
    end
    check("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 40) begin n++; @(negedge clk); end
    check("b_latency", n, LAT);
    ok = addr_ok(a) && len == 8'd0 && last;
    check("bresp", 32'(bresp), ok ? 32'd0 : 32'd2);
    if (ok)
      for (int b = 0; b < 4; b++)
        if (s[b]) mm[(a - BASE) >> 2][8*b +: 8] = d[8*b +: 8];
    hold = $urandom_range(0, 2);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [31:0] pat, input bit use_pat,
                         input int abort_beat);
    int          beat, cyc, n;
    bit          hs, err, rr;
    logic [31:0] ba, exp_d;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; arlen = len; arsize = size; arburst = burst;
    n = 0; hs = 0;
    while (!hs && n < 20) begin
      hs = arready;
      @(posedge clk);
      if (!hs) @(negedge clk);
      n++;
    end
    check("ar_accepted", 32'(hs), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 40) begin n++; @(negedge clk); end
    check("r_latency", n, LAT);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      ba    = (burst == 2'b01) ? a + 32'(beat) * (32'd1 << size) : a;
      err   = burst[1] || size > 3'd2 || !addr_ok(ba);
      exp_d = err ? 32'd0 : mm[(ba - BASE) >> 2];
      check($sformatf("rvalid b%0d", beat), 32'(rvalid), 32'd1);
      check($sformatf("rdata b%0d", beat), rdata, exp_d);
      check($sformatf("rresp b%0d", beat), 32'(rresp), err ? 32'd2 : 32'd0);
      check($sformatf("rlast b%0d", beat), 32'(rlast), 32'(beat == int'(len)));
      last_rdata = rdata;
      if (beat == abort_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_readies", {29'd0, arready, awready, wready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rready = 1'b0;
        @(negedge clk);
        check("post_rst_readies", {29'd0, arready, awready, wready}, 32'd7);
        check("post_rst_rvalid", 32'(rvalid), 32'd0);
        return;
      end
      rr = use_pat ? pat[cyc % 32] : ($urandom_range(0, 3) != 0);
      rready = rr;
      @(negedge clk);
      rready = 1'b0;
      if (rr) beat++;
      cyc++;
    end
    check("r_done", 32'(beat), 32'(len) + 32'd1);
    check("r_idle_rvalid", 32'(rvalid), 32'd0);
    check("r_idle_arready", 32'(arready), 32'd1);
  endtask

  initial begin
    logic [1:0]  rb;
    logic [2:0]  rs;
    logic [31:0] ra;
    int          sel;
    rst_n = 1'b0;
    araddr = '0; arvalid = 0; arlen = '0; arsize = '0; arburst = '0; rready = 0;
    awaddr = '0; awvalid = 0; awlen = '0; wdata = '0; wstrb = '0; wvalid = 0; wlast = 0;
    bready = 0;
    repeat (3) @(negedge clk);
    check("reset_readies", {29'd0, arready, awready, wready}, 32'd0);
    check("reset_valids", {29'd0, rvalid, bvalid, rlast}, 32'd0);
    check("reset_resp", {28'd0, rresp, bresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_readies", {29'd0, arready, awready, wready}, 32'd7);

    for (int i = 0; i < DEPTH; i++)
      do_write(BASE + 32'(4 * i), $urandom, 4'hF, 8'd0, 1'b1, $urandom_range(0, 4) - 2);

    do_write(BASE, 32'hDEADBEEF, 4'hF, 8'd0, 1'b1, 0);
    do_read(BASE, 8'd0, 3'd2, 2'b01, '1, 1, -1);
    check("deadbeef", last_rdata, 32'hDEADBEEF);
    do_write(BASE, 32'h0000AB00, 4'b0010, 8'd0, 1'b1, 3);
    do_read(BASE, 8'd0, 3'd2, 2'b01, '1, 1, -1);
    check("byte_merge", last_rdata, 32'hDEADABEF);
    do_write(BASE + 32'd12, 32'h1234_5678, 4'b1001, 8'd0, 1'b1, -3);

    do_read(BASE + 32'd4, 8'd3, 3'd2, 2'b01, 32'b11101, 1, -1);

    do_read(BASE + 32'(4 * DEPTH), 8'd0, 3'd2, 2'b01, '1, 1, -1);
    check("oor_rdata", last_rdata, 32'd0);
    do_write(BASE + 32'd8, 32'hCAFE_F00D, 4'hF, 8'd1, 1'b1, 0);
    do_write(BASE + 32'd16, 32'hCAFE_F00D, 4'hF, 8'd0, 1'b0, 1);
    do_write(BASE - 32'd4, 32'hCAFE_F00D, 4'hF, 8'd0, 1'b1, 0);
    do_read(BASE + 32'd8, 8'd2, 3'd2, 2'b01, '1, 1, -1);
    do_read(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 3'd2, 2'b01, 32'b0110, 1, -1);
    do_read(BASE + 32'd20, 8'd3, 3'd2, 2'b00, '1, 1, -1);
    do_read(BASE + 32'd20, 8'd1, 3'd2, 2'b10, '1, 1, -1);
    do_read(BASE + 32'd20, 8'd1, 3'd3, 2'b01, '1, 1, -1);

    for (int it = 0; it < 40; it++) begin
      ra = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      if ($urandom_range(0, 7) == 0) ra = BASE + 32'(4 * DEPTH) - 32'd8;
      if ($urandom_range(0, 1) == 0) begin
        do_write(ra, $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0,
                 ($urandom_range(0, 7) != 0), $urandom_range(0, 6) - 3);
      end else begin
        sel = $urandom_range(0, 9);
        rb  = (sel < 7) ? 2'b01 : (sel == 7) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
        sel = $urandom_range(0, 9);
        rs  = (sel < 7) ? 3'd2 : (sel == 7) ? 3'd0 : (sel == 8) ? 3'd1 : 3'($urandom_range(3, 7));
        do_read(ra, 8'($urandom_range(0, 7)), rs, rb, 32'd0, 0, -1);
      end
    end

    do_read(BASE, 8'd7, 3'd2, 2'b01, '1, 1, 1);
    do_read(BASE + 32'd12, 8'd1, 3'd2, 2'b01, '1, 1, -1);
    check("after_rst_data", last_rdata, mm[4]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
